// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions: cache line type and memory arbiter states.
package lc3b_types;

  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    arb_idle,
    arb_serve_i,
    arb_serve_d
  } lc3b_arb_state;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates the I-cache and D-cache onto one physical memory port, one transaction at a time.
// Tie-break is fixed D-over-I unless CACHE_ARBITER_RR_EN is defined (round-robin).
module cache_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  lc3b_arb_state state_reg;
  logic          i_req;
  logic          d_req;
  logic          grant_d;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

`ifdef CACHE_ARBITER_RR_EN
  // 1 = D was granted last; reset favours D on the first tie.
  logic last_grant_reg;
  assign grant_d = d_req & (~i_req | ~last_grant_reg);
`else
  assign grant_d = d_req;
`endif

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign i_pmem_resp  = (state_reg == arb_serve_i) & pmem_resp;
  assign d_pmem_resp  = (state_reg == arb_serve_d) & pmem_resp;

  // pmem outputs are the latched request itself, so they are zero whenever the FSM is idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= arb_idle;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
`ifdef CACHE_ARBITER_RR_EN
      last_grant_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        arb_idle: begin
          if (i_req | d_req) begin
            state_reg    <= grant_d ? arb_serve_d : arb_serve_i;
            pmem_address <= grant_d ? d_pmem_address : i_pmem_address;
            // read and write together is treated as a write
            pmem_write   <= grant_d & d_pmem_write;
            pmem_read    <= grant_d ? ~d_pmem_write : 1'b1;
            pmem_wdata   <= (grant_d & d_pmem_write) ? d_pmem_wdata : '0;
`ifdef CACHE_ARBITER_RR_EN
            last_grant_reg <= grant_d;
`endif
          end
        end
        arb_serve_i, arb_serve_d: begin
          if (pmem_resp) begin
            state_reg    <= arb_idle;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
          end
        end
        default: state_reg <= arb_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: randomized I/D traffic against a transaction-level model,
// plus directed tie-break, drop-after-grant and asynchronous reset scenarios.
module tb_cache_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;
  localparam logic [LW-1:0] WD_C = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam int M_OFF = 0, M_RAND = 1, M_BOTH = 2, M_DW = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_pmem_read = 1'b0;
  logic [AW-1:0] i_pmem_address = '0;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read = 1'b0;
  logic          d_pmem_write = 1'b0;
  logic [AW-1:0] d_pmem_address = '0;
  logic [LW-1:0] d_pmem_wdata = '0;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            side_d;
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } txn_t;

  txn_t exp_q[$];
  txn_t cur;
  bit   resp_sides[$];
  int   n_cmp = 0, n_bad = 0;
  int   mode = M_OFF;
  bit   mem_hold = 1'b0;
  bit   m_busy = 1'b0, m_side_d = 1'b0, m_last_d = 1'b0;
  bit   in_txn = 1'b0;
  int   i_resp_cnt = 0, d_resp_cnt = 0;
  int   i_ack = 0, d_ack = 0;
  bit   i_done, d_done;
  bit   i_wait = 1'b0, d_wait = 1'b0;
  bit   mem_busy = 1'b0;
  int   mem_lat = 0;
  logic [AW-1:0] mem_addr = '0;

  function automatic logic [LW-1:0] mem_data(input logic [AW-1:0] a);
    return {8{a}} ^ {16{8'hA5}};
  endfunction

  task automatic chk(input bit ok, input string name, input string act, input string req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %s, required %s (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: one transaction at a time, granted at an edge where the arbiter is free.
  initial forever begin
    @(posedge clk);
    if (!reset_n) begin
      m_busy = 1'b0;
      m_last_d = 1'b0;
      exp_q.delete();
    end else if (m_busy) begin
      if (pmem_resp) m_busy = 1'b0;
    end else if (i_pmem_read || d_pmem_read || d_pmem_write) begin
      bit   want_d;
      txn_t t;
      want_d = d_pmem_read || d_pmem_write;
`ifdef CACHE_ARBITER_RR_EN
      if (want_d && i_pmem_read) want_d = !m_last_d;
`endif
      m_last_d = want_d;
      t.side_d = want_d;
      t.wr     = want_d && d_pmem_write;
      t.addr   = want_d ? d_pmem_address : i_pmem_address;
      t.wdata  = t.wr ? d_pmem_wdata : '0;
      exp_q.push_back(t);
      m_busy   = 1'b1;
      m_side_d = want_d;
    end
  end

  // Memory: random latency, occasional stray resp while nothing is requested.
  initial forever begin
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
    if (!reset_n || mem_hold) begin
      mem_busy = 1'b0;
    end else begin
      pmem_rdata = {4{$urandom}};
      if (mem_busy) begin
        mem_lat--;
        if (mem_lat == 0) begin
          pmem_resp  = 1'b1;
          pmem_rdata = mem_data(mem_addr);
          mem_busy   = 1'b0;
        end
      end else if (pmem_read || pmem_write) begin
        mem_busy = 1'b1;
        mem_lat  = $urandom_range(1, 4);
        mem_addr = pmem_address;
      end else if ($urandom_range(0, 15) == 0) begin
        pmem_resp = 1'b1;
      end
    end
  end

  // Requester driver for both caches.
  initial forever begin
    @(posedge clk);
    #1;
    i_done = (i_resp_cnt != i_ack);
    d_done = (d_resp_cnt != d_ack);
    i_ack  = i_resp_cnt;
    d_ack  = d_resp_cnt;
    if (!reset_n) begin
      i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
      i_wait = 1'b0; d_wait = 1'b0;
    end else if (mode == M_BOTH) begin
      i_pmem_read = 1'b1; i_pmem_address = 16'h1230;
      d_pmem_read = 1'b0; d_pmem_write = 1'b1;
      d_pmem_address = 16'h4000; d_pmem_wdata = WD_C;
      i_wait = 1'b0; d_wait = 1'b0;
    end else begin
      if (i_wait) begin
        if (i_done) begin
          i_wait = 1'b0; i_pmem_read = 1'b0;
        end else if (i_pmem_read && m_busy && !m_side_d && $urandom_range(0, 5) == 0) begin
          i_pmem_read = 1'b0; i_pmem_address = 16'hFFFF;
        end
      end else if (mode == M_RAND && $urandom_range(0, 2) == 0) begin
        i_pmem_read = 1'b1; i_pmem_address = 16'($urandom); i_wait = 1'b1;
      end else begin
        i_pmem_read = 1'b0;
      end
      if (d_wait) begin
        if (d_done) begin
          d_wait = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        end else if ((d_pmem_read || d_pmem_write) && m_busy && m_side_d && $urandom_range(0, 5) == 0) begin
          d_pmem_read = 1'b0; d_pmem_write = 1'b0;
          d_pmem_address = 16'hFFFF; d_pmem_wdata = {4{$urandom}};
        end
      end else if (mode == M_RAND && $urandom_range(0, 2) == 0) begin
        int op;
        op = $urandom_range(0, 2);
        d_pmem_read  = (op != 1);
        d_pmem_write = (op != 0);
        d_pmem_address = 16'($urandom);
        d_pmem_wdata   = {4{$urandom}};
        d_wait = 1'b1;
      end else if (mode == M_DW) begin
        d_pmem_read = 1'b0; d_pmem_write = 1'b1;
        d_pmem_address = 16'h4000; d_pmem_wdata = WD_C; d_wait = 1'b1;
      end else begin
        d_pmem_read = 1'b0; d_pmem_write = 1'b0;
      end
    end
  end

  // Monitor: pops the expected transaction when pmem activity starts, then checks it to completion.
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      in_txn = 1'b0;
    end else begin
      if (!in_txn && exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        in_txn = 1'b1;
      end
      if (in_txn) begin
        chk({pmem_read, pmem_write} === {!cur.wr, cur.wr}, "pmem_op",
            $sformatf("r%0b w%0b", pmem_read, pmem_write), $sformatf("r%0b w%0b", !cur.wr, cur.wr));
        chk(pmem_address === cur.addr, "pmem_address",
            $sformatf("%h", pmem_address), $sformatf("%h", cur.addr));
        chk(pmem_wdata === cur.wdata, "pmem_wdata",
            $sformatf("%h", pmem_wdata), $sformatf("%h", cur.wdata));
        chk({i_pmem_resp, d_pmem_resp} === (pmem_resp ? {!cur.side_d, cur.side_d} : 2'b00), "resp_side",
            $sformatf("i%0b d%0b", i_pmem_resp, d_pmem_resp),
            $sformatf("i%0b d%0b", pmem_resp && !cur.side_d, pmem_resp && cur.side_d));
        if (pmem_resp) begin
          chk((cur.side_d ? d_pmem_rdata : i_pmem_rdata) === mem_data(cur.addr), "resp_rdata",
              $sformatf("%h", cur.side_d ? d_pmem_rdata : i_pmem_rdata), $sformatf("%h", mem_data(cur.addr)));
          in_txn = 1'b0;
        end
      end else begin
        chk({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} === 4'b0 && pmem_address === '0
            && pmem_wdata === '0, "idle_outputs",
            $sformatf("r%0b w%0b ir%0b dr%0b a=%h", pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, pmem_address),
            "all zero");
      end
      if (i_pmem_resp) i_resp_cnt++;
      if (d_pmem_resp) d_resp_cnt++;
      if (i_pmem_resp || d_pmem_resp) resp_sides.push_back(d_pmem_resp);
    end
  end

  task automatic drain();
    int k;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      #2;
      if (!i_wait && !d_wait && !m_busy && !in_txn && exp_q.size() == 0) break;
    end
    chk(k < 1000, "drain", $sformatf("busy after %0d cycles", k), "idle");
  endtask

  initial begin
    bit exp_s[3];
    int start;
    int k;
`ifdef CACHE_ARBITER_RR_EN
    exp_s = '{1'b1, 1'b0, 1'b1};
`else
    exp_s = '{1'b1, 1'b1, 1'b1};
`endif
    repeat (3) @(posedge clk);
    #1;
    chk({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} === 4'b0 && pmem_address === '0 && pmem_wdata === '0,
        "reset_state", $sformatf("r%0b w%0b a=%h", pmem_read, pmem_write, pmem_address), "all zero");
    @(negedge clk);
    reset_n = 1'b1;

    // Both caches held requesting: first three grants show the tie-break order.
    start = resp_sides.size();
    mode = M_BOTH;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      #2;
      if (resp_sides.size() >= start + 3) break;
    end
    mode = M_OFF;
    for (int j = 0; j < 3; j++) begin
      chk(resp_sides.size() > start + j && resp_sides[start + j] == exp_s[j], $sformatf("tie_grant%0d", j),
          resp_sides.size() > start + j ? (resp_sides[start + j] ? "D" : "I") : "none", exp_s[j] ? "D" : "I");
    end
    drain();

    mode = M_RAND;
    repeat (3000) @(posedge clk);
    mode = M_OFF;
    drain();

    // D write held in SERVE_D with no memory response, then reset asserted mid-transaction.
    mem_hold = 1'b1;
    mode = M_DW;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (pmem_write) break;
    end
    chk(pmem_write === 1'b1, "dwrite_start", $sformatf("%0b", pmem_write), "1");
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b0;
    mode = M_OFF;
    #1;
    chk({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} === 4'b0 && pmem_address === '0 && pmem_wdata === '0,
        "async_reset", $sformatf("r%0b w%0b dr%0b a=%h", pmem_read, pmem_write, d_pmem_resp, pmem_address),
        "all zero");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    mem_hold = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} === 4'b0, "post_reset_idle",
          $sformatf("r%0b w%0b ir%0b dr%0b", pmem_read, pmem_write, i_pmem_resp, d_pmem_resp), "0000");
    end

    mode = M_RAND;
    repeat (500) @(posedge clk);
    mode = M_OFF;
    drain();
    chk(exp_q.size() == 0 && !in_txn, "scoreboard_empty", $sformatf("%0d left", exp_q.size()), "0 left");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, physical address width.
REQ-002 SHALL have parameter LINE_W, default 128, cache line width in bits.
REQ-003 SHALL have ports: clk  in  1  sole clock; reset_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have I-side ports: i_pmem_read  in  1; i_pmem_address  in  ADDR_W; i_pmem_rdata  out  LINE_W; i_pmem_resp  out  1.
REQ-005 SHALL have D-side ports: d_pmem_read  in  1; d_pmem_write  in  1; d_pmem_address  in  ADDR_W; d_pmem_wdata  in  LINE_W; d_pmem_rdata  out  LINE_W; d_pmem_resp  out  1.
REQ-006 SHALL have memory-side ports: pmem_read  out  1; pmem_write  out  1; pmem_address  out  ADDR_W; pmem_wdata  out  LINE_W; pmem_rdata  in  LINE_W; pmem_resp  in  1.

Function
REQ-007 SHALL implement FSM states IDLE, SERVE_I, SERVE_D.
REQ-008 SHALL, in IDLE, treat a request as pending when i_pmem_read is high (I) or d_pmem_read|d_pmem_write is high (D).
REQ-009 SHALL transition from IDLE to SERVE_I or SERVE_D on the clock edge where a request is pending; single pending request is granted; simultaneous requests follow REQ-019/020.
REQ-010 SHALL latch, at the grant edge, the granted requester's address, op (read/write) and, for D writes, wdata.
REQ-011 SHALL drive pmem_read/pmem_write/pmem_address/pmem_wdata from the latched values only while in SERVE_x; in IDLE all pmem outputs are 0.
REQ-012 SHALL treat d_pmem_read and d_pmem_write both high as a write.
REQ-013 SHALL, in SERVE_x with pmem_resp high, assert the matching x_pmem_resp combinationally in that same cycle and pass pmem_rdata to x_pmem_rdata; the state returns to IDLE on the next edge.
REQ-014 SHALL drive i_pmem_rdata and d_pmem_rdata from pmem_rdata at all times; the non-granted resp is always 0.
REQ-015 SHALL complete a granted transaction using the latched values even if the requester deasserts mid-transaction; resp still pulses.
REQ-016 SHALL spend at least one IDLE cycle between transactions (grant-to-pmem-request latency is 1 cycle).
REQ-017 SHALL ignore pmem_resp while in IDLE.

Reset
REQ-018 SHALL, on reset_n low (any time, including mid-transaction), go to IDLE immediately, clear the latches and the priority bit, and drive all outputs to 0; the aborted transaction produces no resp.

Configuration
REQ-019 SHALL, with macro CACHE_ARBITER_RR_EN defined, resolve simultaneous requests round-robin using a 1-bit last_grant register (updated at each grant; reset value = I granted last, so D wins first tie).
REQ-020 SHALL, without CACHE_ARBITER_RR_EN, resolve simultaneous requests with fixed D-over-I priority; no last_grant register exists.

Structure
REQ-021 SHALL add to the shared lc3b_types package: typedef lc3b_line (logic [127:0]) and enum lc3b_arb_state {arb_idle, arb_serve_i, arb_serve_d}.
REQ-022 SHALL be a single module with no sub-module.

Verification
REQ-023 SHALL verify: I read only, address 16'h1230, memory returns 128'hA5..A5 after 3 cycles -> pmem_read high 1 cycle after request, i_pmem_resp one-cycle pulse with data, d_pmem_resp stays 0.
REQ-024 SHALL verify: D write, address 16'h4000, wdata 128'h0123..CDEF -> pmem_write=1, pmem_address/wdata match, d_pmem_resp pulse on pmem_resp.
REQ-025 SHALL verify: I and D both asserted in IDLE, repeated 3 times -> without macro D,D,D served first each time; with macro D, I, D order of first grants.
REQ-026 SHALL verify: D request arriving while SERVE_I is waiting -> I completes, one IDLE cycle, then SERVE_D; no pmem signal changes mid-I transaction.
REQ-027 SHALL verify: reset_n pulled low 2 cycles into SERVE_D -> pmem_write drops asynchronously, no resp, FSM in IDLE after release.
REQ-028 SHALL verify: I request dropped after grant, address input changed to 16'hFFFF -> pmem_address holds latched 16'h1230 until pmem_resp.
